// File: rtl/cpu_irq_service_monitor.sv
// cpu_irq_service_monitor
// Watches the CPU bus for the 6502 interrupt entry sequence: three consecutive
// stack pushes (PCH, PCL, P), then the two-byte vector fetch. Each completed
// entry is reported as an IRQ, BRK or NMI pulse, and the pushed PC and P are
// captured. IRQ latency is measured in CPU cycles from irq_n going low.
//
// Every cycle where the next step of the sequence does not match sends the
// tracker back to IDLE. If that cycle is itself a stack write, it is treated
// as the first push of a new entry, so one stray write before a real entry
// does not hide that entry.
module cpu_irq_service_monitor #(
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_cycle,
    input  logic [15:0]      cpu_addr,
    input  logic             cpu_rw,
    input  logic [7:0]       cpu_data,
    input  logic             irq_n,
    output logic             irq_taken,
    output logic             brk_taken,
    output logic             nmi_taken,
    output logic [15:0]      pushed_pc,
    output logic [7:0]       pushed_p,
    output logic [LAT_W-1:0] irq_latency,
    output logic [15:0]      irq_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH2 = 3'd1,
        S_PUSH3 = 3'd2,
        S_VECL  = 3'd3,
        S_VECH  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Values captured while the entry sequence is in progress
    logic [7:0]       pch;
    logic [7:0]       pcl;
    logic [7:0]       p_cap;
    logic [7:0]       sp0;
    logic             vec_nmi;
    logic [LAT_W-1:0] lat_cnt;

    // Bus decode for the current cycle
    logic       stack_write;
    logic [7:0] sp_m1;
    logic [7:0] sp_m2;
    logic       push2_hit;
    logic       push3_hit;
    logic       vecl_irq;
    logic       vecl_nmi;
    logic       vech_hit;

    // Control strobes from the output decoder
    logic cap_pch;
    logic cap_pcl;
    logic cap_p;
    logic cap_vec;
    logic complete;

    assign stack_write = !cpu_rw && (cpu_addr[15:8] == 8'h01);
    assign sp_m1       = sp0 - 8'd1;
    assign sp_m2       = sp0 - 8'd2;
    assign push2_hit   = stack_write && (cpu_addr[7:0] == sp_m1);
    assign push3_hit   = stack_write && (cpu_addr[7:0] == sp_m2);
    assign vecl_irq    = cpu_rw && (cpu_addr == 16'hFFFE);
    assign vecl_nmi    = cpu_rw && (cpu_addr == 16'hFFFA);
    assign vech_hit    = cpu_rw && (cpu_addr == (vec_nmi ? 16'hFFFB : 16'hFFFF));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a mismatch restarts at PUSH2 when the cycle is a stack write
    always_comb begin
        state_next = state;
        if (cpu_cycle) begin
            case (state)
                S_IDLE:  state_next = stack_write ? S_PUSH2 : S_IDLE;
                S_PUSH2: state_next = push2_hit ? S_PUSH3 :
                                      (stack_write ? S_PUSH2 : S_IDLE);
                S_PUSH3: state_next = push3_hit ? S_VECL :
                                      (stack_write ? S_PUSH2 : S_IDLE);
                S_VECL:  state_next = (vecl_irq || vecl_nmi) ? S_VECH :
                                      (stack_write ? S_PUSH2 : S_IDLE);
                S_VECH:  state_next = vech_hit ? S_IDLE :
                                      (stack_write ? S_PUSH2 : S_IDLE);
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output decode: capture strobes and the completion strobe
    always_comb begin
        cap_pch  = 1'b0;
        cap_pcl  = 1'b0;
        cap_p    = 1'b0;
        cap_vec  = 1'b0;
        complete = 1'b0;
        if (cpu_cycle) begin
            case (state)
                S_IDLE: begin
                    cap_pch = stack_write;
                end
                S_PUSH2: begin
                    cap_pcl = push2_hit;
                    cap_pch = !push2_hit && stack_write;
                end
                S_PUSH3: begin
                    cap_p   = push3_hit;
                    cap_pch = !push3_hit && stack_write;
                end
                S_VECL: begin
                    cap_vec = vecl_irq || vecl_nmi;
                    cap_pch = !(vecl_irq || vecl_nmi) && stack_write;
                end
                S_VECH: begin
                    complete = vech_hit;
                    cap_pch  = !vech_hit && stack_write;
                end
                default: begin
                    cap_pch = 1'b0;
                end
            endcase
        end
    end

    // Capture registers for the entry in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            pch     <= 8'h00;
            pcl     <= 8'h00;
            p_cap   <= 8'h00;
            sp0     <= 8'h00;
            vec_nmi <= 1'b0;
        end else begin
            if (cap_pch) begin
                pch <= cpu_data;
                sp0 <= cpu_addr[7:0];
            end
            if (cap_pcl) begin
                pcl <= cpu_data;
            end
            if (cap_p) begin
                p_cap <= cpu_data;
            end
            if (cap_vec) begin
                vec_nmi <= vecl_nmi;
            end
        end
    end

    // Latency counter: counts CPU cycles with irq_n low, saturating; clears when high
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (cpu_cycle) begin
            if (irq_n) begin
                lat_cnt <= '0;
            end else if (!(&lat_cnt)) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
        end
    end

    // Completion outputs: one-clock classified pulse plus captured PC/P and IRQ stats
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_taken   <= 1'b0;
            brk_taken   <= 1'b0;
            nmi_taken   <= 1'b0;
            pushed_pc   <= 16'h0000;
            pushed_p    <= 8'h00;
            irq_latency <= '0;
            irq_count   <= 16'h0000;
        end else begin
            irq_taken <= 1'b0;
            brk_taken <= 1'b0;
            nmi_taken <= 1'b0;
            if (complete) begin
                pushed_pc <= {pch, pcl};
                pushed_p  <= p_cap;
                if (vec_nmi) begin
                    nmi_taken <= 1'b1;
                end else if (p_cap[4]) begin
                    brk_taken <= 1'b1;
                end else begin
                    irq_taken <= 1'b1;
                    irq_count <= irq_count + 16'd1;
                    // Line already released means no pending IRQ to measure
                    irq_latency <= irq_n ? '0 : lat_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_irq_service_monitor.sv
// Testbench for cpu_irq_service_monitor. Two instances share the bus: the
// default 16-bit latency counter and a 4-bit one for saturation. CPU cycles
// are separated by idle clocks carrying stack-write-like bus noise.
module tb_cpu_irq_service_monitor;

    localparam logic [1:0] K_IRQ = 2'd1;
    localparam logic [1:0] K_BRK = 2'd2;
    localparam logic [1:0] K_NMI = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] pc;
        logic [7:0]  p;
        logic [15:0] lat;
        logic [15:0] cnt;
    } exp_t;

    // clock / reset and bus
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_cycle;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data;
    logic        irq_n;

    // default instance outputs
    logic        irq_taken, brk_taken, nmi_taken;
    logic [15:0] pushed_pc;
    logic [7:0]  pushed_p;
    logic [15:0] irq_latency;
    logic [15:0] irq_count;

    // 4-bit latency instance outputs
    logic        irq_taken_s, brk_taken_s, nmi_taken_s;
    logic [15:0] pushed_pc_s;
    logic [7:0]  pushed_p_s;
    logic [3:0]  irq_latency_s;
    logic [15:0] irq_count_s;

    // scoreboard
    logic [57:0] exp_q[$];
    logic [15:0] exp_lat;
    logic [15:0] exp_count;
    int          checks = 0;
    int          errors = 0;
    int          seen_pulses = 0;

    always #5 clk = ~clk;

    cpu_irq_service_monitor dut (
        .clk(clk), .reset(reset), .cpu_cycle(cpu_cycle), .cpu_addr(cpu_addr),
        .cpu_rw(cpu_rw), .cpu_data(cpu_data), .irq_n(irq_n),
        .irq_taken(irq_taken), .brk_taken(brk_taken), .nmi_taken(nmi_taken),
        .pushed_pc(pushed_pc), .pushed_p(pushed_p),
        .irq_latency(irq_latency), .irq_count(irq_count)
    );

    cpu_irq_service_monitor #(.LAT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .cpu_cycle(cpu_cycle), .cpu_addr(cpu_addr),
        .cpu_rw(cpu_rw), .cpu_data(cpu_data), .irq_n(irq_n),
        .irq_taken(irq_taken_s), .brk_taken(brk_taken_s), .nmi_taken(nmi_taken_s),
        .pushed_pc(pushed_pc_s), .pushed_p(pushed_p_s),
        .irq_latency(irq_latency_s), .irq_count(irq_count_s)
    );

    // Scoreboard side: on any pulse, pop the expected entry and compare
    task automatic check_outputs();
        exp_t       ev;
        logic [1:0] got_kind;
        logic [2:0] exp_hot;
        logic [3:0] sat_lat;
        int         n;
        n = int'(irq_taken) + int'(brk_taken) + int'(nmi_taken);
        if (n != 0 || irq_taken_s || brk_taken_s || nmi_taken_s) begin
            seen_pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_entry: irq/brk/nmi=%b%b%b sat=%b%b%b, required no pulse",
                         irq_taken, brk_taken, nmi_taken, irq_taken_s, brk_taken_s, nmi_taken_s);
            end else begin
                ev = exp_q.pop_front();
                got_kind = irq_taken ? K_IRQ : brk_taken ? K_BRK : nmi_taken ? K_NMI : 2'd0;
                if (n != 1 || got_kind !== ev.kind || pushed_pc !== ev.pc || pushed_p !== ev.p ||
                    irq_latency !== ev.lat || irq_count !== ev.cnt) begin
                    errors++;
                    $display("FAIL entry: pulses=%0d kind=%0d pc=%h p=%h lat=%0d cnt=%0d, required 1 kind=%0d pc=%h p=%h lat=%0d cnt=%0d",
                             n, got_kind, pushed_pc, pushed_p, irq_latency, irq_count,
                             ev.kind, ev.pc, ev.p, ev.lat, ev.cnt);
                end
                exp_hot = (ev.kind == K_IRQ) ? 3'b100 : (ev.kind == K_BRK) ? 3'b010 : 3'b001;
                sat_lat = (ev.lat > 16'd15) ? 4'hF : ev.lat[3:0];
                checks++;
                if ({irq_taken_s, brk_taken_s, nmi_taken_s} !== exp_hot || irq_latency_s !== sat_lat ||
                    pushed_pc_s !== ev.pc || irq_count_s !== ev.cnt) begin
                    errors++;
                    $display("FAIL entry_sat: pulses=%b lat=%0d pc=%h cnt=%0d, required %b lat=%0d pc=%h cnt=%0d",
                             {irq_taken_s, brk_taken_s, nmi_taken_s}, irq_latency_s, pushed_pc_s,
                             irq_count_s, exp_hot, sat_lat, ev.pc, ev.cnt);
                end
            end
        end
    endtask

    // One clock: sample outputs on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // One CPU cycle followed by an idle clock carrying stack-write noise
    task automatic bus(input logic [15:0] addr, input logic rw, input logic [7:0] data);
        cpu_cycle = 1'b1;
        cpu_addr  = addr;
        cpu_rw    = rw;
        cpu_data  = data;
        tick();
        cpu_cycle = 1'b0;
        cpu_addr  = {8'h01, 8'($urandom_range(0, 255))};
        cpu_rw    = 1'b0;
        cpu_data  = 8'($urandom_range(0, 255));
        tick();
    endtask

    task automatic idle_reads(input int n);
        for (int i = 0; i < n; i++) begin
            bus(16'h8000, 1'b1, 8'($urandom_range(0, 255)));
        end
    endtask

    // Full entry sequence; pushes the expected result before the vector-high cycle
    task automatic entry(input logic [7:0] sp0, input logic [15:0] pc, input logic [7:0] p,
                         input logic is_nmi, input logic [15:0] lat, input logic rel);
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [15:0] vec;
        exp_t        ev;
        s1  = sp0 - 8'd1;
        s2  = sp0 - 8'd2;
        vec = is_nmi ? 16'hFFFA : 16'hFFFE;
        bus({8'h01, sp0}, 1'b0, pc[15:8]);
        bus({8'h01, s1}, 1'b0, pc[7:0]);
        bus({8'h01, s2}, 1'b0, p);
        bus(vec, 1'b1, 8'h00);
        if (is_nmi) begin
            ev.kind = K_NMI;
        end else if (p[4]) begin
            ev.kind = K_BRK;
        end else begin
            ev.kind   = K_IRQ;
            exp_count = exp_count + 16'd1;
            exp_lat   = lat;
        end
        ev.pc  = pc;
        ev.p   = p;
        ev.lat = exp_lat;
        ev.cnt = exp_count;
        exp_q.push_back(ev);
        if (rel) irq_n = 1'b1;
        bus(vec + 16'd1, 1'b1, 8'h80);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        cpu_cycle = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_rw    = 1'b1;
        cpu_data  = 8'h00;
        irq_n     = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        exp_lat   = 16'h0000;
        exp_count = 16'h0000;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({irq_taken, brk_taken, nmi_taken} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b, required 000", {irq_taken, brk_taken, nmi_taken});
        end
        checks++;
        if (pushed_pc !== 16'h0000 || pushed_p !== 8'h00) begin
            errors++; $display("FAIL reset_pushed: pc=%h p=%h, required 0000 00", pushed_pc, pushed_p);
        end
        checks++;
        if (irq_latency !== 16'h0000 || irq_count !== 16'h0000) begin
            errors++; $display("FAIL reset_stats: lat=%0d cnt=%0d, required 0 0", irq_latency, irq_count);
        end
        checks++;
        if ({irq_taken_s, brk_taken_s, nmi_taken_s} !== 3'b000 || irq_latency_s !== 4'h0 ||
            irq_count_s !== 16'h0000 || pushed_pc_s !== 16'h0000 || pushed_p_s !== 8'h00) begin
            errors++; $display("FAIL reset_sat: lat=%0d cnt=%0d pc=%h, required all 0", irq_latency_s, irq_count_s, pushed_pc_s);
        end
    endtask

    task automatic test_irq();
        int p0;
        p0 = seen_pulses;
        irq_n = 1'b0;
        idle_reads(9);
        entry(8'hFD, 16'h1234, 8'hA0, 1'b0, 16'd13, 1'b0);
        irq_n = 1'b1;
        checks++;
        if (seen_pulses - p0 != 1) begin
            errors++; $display("FAIL irq_pulse_count: got %0d, required 1", seen_pulses - p0);
        end
        checks++;
        if (irq_count !== 16'd1 || irq_latency !== 16'd13) begin
            errors++; $display("FAIL irq_hold: cnt=%0d lat=%0d, required 1 13", irq_count, irq_latency);
        end
    endtask

    task automatic test_brk();
        int p0;
        p0 = seen_pulses;
        entry(8'hFD, 16'h1234, 8'h30, 1'b0, 16'd0, 1'b0);
        checks++;
        if (seen_pulses - p0 != 1 || irq_count !== 16'd1 || irq_latency !== 16'd13) begin
            errors++; $display("FAIL brk_stats: pulses=%0d cnt=%0d lat=%0d, required 1 1 13",
                               seen_pulses - p0, irq_count, irq_latency);
        end
    endtask

    task automatic test_nmi();
        int p0;
        p0 = seen_pulses;
        entry(8'h80, 16'hABCD, 8'h24, 1'b1, 16'd0, 1'b0);
        entry(8'h01, 16'h5678, 8'h35, 1'b1, 16'd0, 1'b0);
        checks++;
        if (seen_pulses - p0 != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL nmi_pulse_count: got %0d pending %0d, required 2 0",
                               seen_pulses - p0, exp_q.size());
        end
    endtask

    task automatic test_broken();
        int p0;
        p0 = seen_pulses;
        // non-consecutive pushes
        bus(16'h01FD, 1'b0, 8'h12);
        bus(16'h01FB, 1'b0, 8'h34);
        bus(16'hFFFE, 1'b1, 8'h00);
        bus(16'hFFFF, 1'b1, 8'h80);
        // wrong vector-high address
        bus(16'h01FD, 1'b0, 8'h12);
        bus(16'h01FC, 1'b0, 8'h34);
        bus(16'h01FB, 1'b0, 8'hA0);
        bus(16'hFFFE, 1'b1, 8'h00);
        bus(16'h8000, 1'b1, 8'h80);
        // wrong vector-low address
        bus(16'h01FD, 1'b0, 8'h12);
        bus(16'h01FC, 1'b0, 8'h34);
        bus(16'h01FB, 1'b0, 8'hA0);
        bus(16'hFFFC, 1'b1, 8'h00);
        bus(16'hFFFD, 1'b1, 8'h80);
        checks++;
        if (seen_pulses - p0 != 0) begin
            errors++; $display("FAIL broken_no_pulse: got %0d pulses, required 0", seen_pulses - p0);
        end
    endtask

    task automatic test_restart();
        int p0;
        p0 = seen_pulses;
        irq_n = 1'b0;
        bus(16'h0150, 1'b0, 8'h77);
        entry(8'hFD, 16'h4321, 8'hA0, 1'b0, 16'd5, 1'b0);
        irq_n = 1'b1;
        checks++;
        if (seen_pulses - p0 != 1 || irq_count !== 16'd2) begin
            errors++; $display("FAIL restart: pulses=%0d cnt=%0d, required 1 2", seen_pulses - p0, irq_count);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = seen_pulses;
        // line released on the vector-high cycle with a nonzero count pending
        irq_n = 1'b0;
        entry(8'hFD, 16'h1111, 8'h00, 1'b0, 16'd0, 1'b1);
        entry(8'hFA, 16'h2222, 8'h04, 1'b0, 16'd0, 1'b0);
        checks++;
        if (seen_pulses - p0 != 2 || irq_count !== 16'd4 || irq_latency !== 16'd0) begin
            errors++; $display("FAIL back_to_back: pulses=%0d cnt=%0d lat=%0d, required 2 4 0",
                               seen_pulses - p0, irq_count, irq_latency);
        end
    endtask

    task automatic test_saturation();
        irq_n = 1'b0;
        idle_reads(40);
        entry(8'hFD, 16'hBEEF, 8'h00, 1'b0, 16'd44, 1'b0);
        irq_n = 1'b1;
        checks++;
        if (irq_latency_s !== 4'hF || irq_latency !== 16'd44) begin
            errors++; $display("FAIL saturation: sat lat=%0d wide lat=%0d, required 15 44", irq_latency_s, irq_latency);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = seen_pulses;
        irq_n = 1'b0;
        bus(16'h01FD, 1'b0, 8'h12);
        bus(16'h01FC, 1'b0, 8'h34);
        bus(16'h01FB, 1'b0, 8'hA0);
        bus(16'hFFFE, 1'b1, 8'h00);
        reset     = 1'b1;
        cpu_cycle = 1'b0;
        tick();
        reset     = 1'b0;
        exp_lat   = 16'h0000;
        exp_count = 16'h0000;
        bus(16'hFFFF, 1'b1, 8'h80);
        irq_n = 1'b1;
        checks++;
        if (seen_pulses - p0 != 0 || {irq_taken, brk_taken, nmi_taken} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_pulse: pulses=%0d, required 0", seen_pulses - p0);
        end
        checks++;
        if (pushed_pc !== 16'h0000 || pushed_p !== 8'h00 || irq_latency !== 16'h0000 || irq_count !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_outputs: pc=%h p=%h lat=%0d cnt=%0d, required all 0",
                               pushed_pc, pushed_p, irq_latency, irq_count);
        end
        checks++;
        if (irq_latency_s !== 4'h0 || irq_count_s !== 16'h0000 || pushed_pc_s !== 16'h0000 || pushed_p_s !== 8'h00) begin
            errors++; $display("FAIL reset_mid_sat: pc=%h p=%h lat=%0d cnt=%0d, required all 0",
                               pushed_pc_s, pushed_p_s, irq_latency_s, irq_count_s);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cpu_cycle = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_rw    = 1'b1;
        cpu_data  = 8'h00;
        irq_n     = 1'b1;
        exp_lat   = 16'h0000;
        exp_count = 16'h0000;
        @(negedge clk);
        test_reset();
        test_irq();
        test_brk();
        test_nmi();
        test_broken();
        test_restart();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_entries: %0d expected entries never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_irq_service_monitor.md
Name: cpu_irq_service_monitor

Overview:
Cartridge-side observer for the CPU end of the mapper IRQ line. It watches the CPU bus for the 6502 interrupt entry sequence: three consecutive stack pushes, then the vector fetch. It reports each serviced IRQ, BRK or NMI with one-clock pulses and captures the pushed PC and P. It also measures IRQ latency in CPU cycles, from the IRQ line asserting to the handler being entered, for debug and status registers.

Parameters:
LAT_W, 16, width of the IRQ latency counter (saturating)

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
cpu_cycle  input  1  one-clk strobe per CPU cycle; bus inputs valid when high
cpu_addr  input  16  CPU address bus
cpu_rw  input  1  1 = read, 0 = write
cpu_data  input  8  CPU data bus (write data or read data)
irq_n  input  1  active-low IRQ line as driven to the CPU
irq_taken  output  1  pulse: IRQ entry completed
brk_taken  output  1  pulse: BRK entry completed
nmi_taken  output  1  pulse: NMI entry completed
pushed_pc  output  16  return PC captured from the last completed entry
pushed_p  output  8  status byte captured from the last completed entry
irq_latency  output  LAT_W  cycles from irq_n low to the last IRQ entry
irq_count  output  16  number of IRQ entries (wraps at 16'hFFFF -> 0)

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, latency counter 0.
- The FSM advances only on clks with cpu_cycle=1. All other clks hold state.
- A stack write (SW) is cpu_rw=0 with cpu_addr[15:8]=8'h01.
- IDLE: on SW, capture PCH = cpu_data and SP0 = cpu_addr[7:0], then go to PUSH2.
- PUSH2: needs SW at low byte SP0-1 (mod 256).
  - Match: capture PCL and go to PUSH3.
  - Mismatch: go to IDLE. If the current cycle is itself an SW, re-enter as PUSH1 (capture it and go to PUSH2).
- PUSH3: needs SW at low byte SP0-2 (mod 256).
  - Match: capture P and go to VECL.
  - Mismatch: handled the same way as in PUSH2.
- VECL: needs a read at 16'hFFFE (IRQ/BRK) or 16'hFFFA (NMI).
  - Match: record the vector kind and go to VECH.
  - Anything else: handled the same way as in PUSH2.
- VECH: needs a read at VECL address + 1.
  - Match: complete the entry; FSM returns to IDLE.
  - Mismatch: discard the entry and apply the PUSH2 rule.
- Stack pointer underflow wrap is legal. Example: SP0=8'h01 expects pushes at 8'h00, then 8'hFF.
- Completion, outputs registered on the clk after the VECH cycle:
  - Exactly one of irq_taken / brk_taken / nmi_taken pulses for one clk.
  - pushed_pc = {PCH,PCL}; pushed_p = P.
- Classification of a completed entry:
  - NMI vector: nmi_taken.
  - IRQ vector with P[4]=1: brk_taken.
  - IRQ vector with P[4]=0: irq_taken. irq_count increments, irq_latency loads the current counter value.
- Latency counter:
  - irq_n is sampled on cpu_cycle.
  - While irq_n=0 the counter increments by 1 per cpu_cycle and saturates at all-ones.
  - When irq_n=1 the counter clears to 0.
  - On the same cpu_cycle as an irq_taken completion, the loaded value is the pre-increment count.
- An IRQ entry while irq_n=1 (line already released) still pulses irq_taken and loads 0 into irq_latency.
- NMI and BRK never modify irq_latency or irq_count.
- Reset mid-sequence: FSM to IDLE, pulses suppressed, captured values and counters cleared.
- Reads during PUSH2/PUSH3 are mismatches. The interrupt sequence has no interleaved cycles, so it never contains them.

Test Plan:
- IRQ entry: irq_n low at cycle 0; writes $01FD=12, $01FC=34, $01FB=A0 (P[4]=0); reads $FFFE, $FFFF on cycles 9-13 -> irq_taken 1 pulse, pushed_pc=16'h1234, pushed_p=8'hA0, irq_latency=13, irq_count=1.
- BRK entry: same sequence with P=8'h30 -> brk_taken only; irq_count and irq_latency unchanged.
- NMI entry: pushes $0180, $017F, $017E, then reads $FFFA, $FFFB -> nmi_taken only. Repeat with SP0=8'h01: pushes at $0101, $0100, $01FF -> nmi_taken (wrap).
- Broken sequences -> no pulse:
  - Pushes $01FD, $01FB (non-consecutive).
  - Read $FFFE, then a read of $8000 instead of $FFFF.
  - A third push followed by a read of $FFFC.
- Restart on mismatch: a stray write to $0150, then a valid IRQ sequence starting next cycle -> exactly one irq_taken.
- Latency saturation and reset: LAT_W=4, irq_n held low for 40 cycles, then IRQ entry -> irq_latency=4'hF. Assert reset between VECL and VECH -> no pulse, all outputs 0.
